// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared command codes, data-command bit positions, state encoding and sizes
package tm1638_pkg;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam int DC_READ_BIT  = 1;
  localparam int DC_FIXED_BIT = 2;
  localparam int RAM_DEPTH    = 16;
  localparam int KEY_W        = 32;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE} state_t;
endpackage

// File: rtl/tm1638_responder_if.sv
// tm1638_responder_if: three-wire TM1638 bus as seen between a master and the device
interface tm1638_responder_if;
  logic stb;
  logic sclk;
  logic dio_in;
  logic dio_out;
  logic dio_oe;
  modport master(output stb, sclk, dio_in, input dio_out, dio_oe);
  modport slave(input stb, sclk, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/tm1638_pin_sync.sv
// tm1638_pin_sync: multi-flop synchroniser for an async pin plus rise/fall detection
module tm1638_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 device-side bus model with 16x8 display RAM and key-scan readback
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tm1638_responder_if.slave    bus,
  input  logic [KEY_W-1:0]     keys,
  input  logic [3:0]           disp_addr,
  output logic [7:0]           disp_data,
  output logic                 display_on,
  output logic [2:0]           brightness,
  output logic                 frame_done
);
  logic stb_lvl, stb_rise, stb_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic dio_lvl, dio_rise_unused, dio_fall_unused;
  tm1638_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb (
    .clk(clk), .rst(rst), .pin(bus.stb), .level(stb_lvl), .rise(stb_rise), .fall(stb_fall));
  tm1638_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst(rst), .pin(bus.sclk), .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  tm1638_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dio (
    .clk(clk), .rst(rst), .pin(bus.dio_in), .level(dio_lvl), .rise(dio_rise_unused), .fall(dio_fall_unused));
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [3:0]        addr_q, addr_d;
  logic              fixed_q, fixed_d;
  logic              stored_q, stored_d;
  logic [KEY_W-1:0]  keys_q, keys_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic              dio_out_q, dio_out_d;
  logic              dio_oe_q, dio_oe_d;
  logic              display_on_q, display_on_d;
  logic [2:0]        brightness_q, brightness_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        disp_data_q, disp_data_d;
  logic [7:0]        ram_q [RAM_DEPTH];
  logic [7:0]        ram_d [RAM_DEPTH];
  logic [7:0]        rx_byte;
  logic              byte_done;
  // LSB-first: the bit arriving now lands in the MSB of the completed byte
  assign rx_byte   = {dio_lvl, shreg_q[7:1]};
  assign byte_done = sclk_rise && !stb_lvl && bit_cnt_q == 3'd7;
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    addr_d       = addr_q;
    fixed_d      = fixed_q;
    stored_d     = stored_q;
    keys_d       = keys_q;
    rd_idx_d     = rd_idx_q;
    dio_out_d    = dio_out_q;
    dio_oe_d     = dio_oe_q;
    display_on_d = display_on_q;
    brightness_d = brightness_q;
    frame_done_d = 1'b0;
    ram_d        = ram_q;
    disp_data_d  = ram_q[disp_addr];
    if (stb_rise) begin
      state_d      = S_IDLE;
      dio_out_d    = 1'b0;
      dio_oe_d     = 1'b0;
      frame_done_d = state_q == S_WDATA && stored_q;
    end else if (stb_fall) begin
      state_d   = S_CMD;
      bit_cnt_d = 3'd0;
      stored_d  = 1'b0;
    end else if (!stb_lvl) begin
      if (sclk_rise) begin
        shreg_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done && state_q == S_CMD) begin
        state_d = S_IGNORE;
        if (rx_byte[7:6] == CMD_DATA) begin
          fixed_d = rx_byte[DC_FIXED_BIT];
          if (rx_byte[DC_READ_BIT]) begin
            keys_d    = keys;
            rd_idx_d  = 5'd0;
            dio_oe_d  = 1'b1;
            dio_out_d = keys[0];
            state_d   = S_RDATA;
          end
        end else if (rx_byte[7:6] == CMD_DISP) begin
          display_on_d = rx_byte[3];
          brightness_d = rx_byte[2:0];
        end else if (rx_byte[7:6] == CMD_ADDR) begin
          addr_d  = rx_byte[3:0];
          state_d = S_WDATA;
        end
      end
      if (byte_done && state_q == S_WDATA) begin
        ram_d[addr_q] = rx_byte;
        addr_d        = fixed_q ? addr_q : addr_q + 4'd1;
        stored_d      = 1'b1;
      end
      if (sclk_fall && state_q == S_RDATA) begin
        rd_idx_d  = rd_idx_q + 5'd1;
        dio_out_d = rd_idx_q == 5'd31 ? 1'b0 : keys_q[rd_idx_d];
        dio_oe_d  = rd_idx_q != 5'd31;
        state_d   = rd_idx_q == 5'd31 ? S_IGNORE : S_RDATA;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      addr_q       <= '0;
      fixed_q      <= 1'b0;
      stored_q     <= 1'b0;
      keys_q       <= '0;
      rd_idx_q     <= '0;
      dio_out_q    <= 1'b0;
      dio_oe_q     <= 1'b0;
      display_on_q <= 1'b0;
      brightness_q <= '0;
      frame_done_q <= 1'b0;
      disp_data_q  <= '0;
      ram_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      addr_q       <= addr_d;
      fixed_q      <= fixed_d;
      stored_q     <= stored_d;
      keys_q       <= keys_d;
      rd_idx_q     <= rd_idx_d;
      dio_out_q    <= dio_out_d;
      dio_oe_q     <= dio_oe_d;
      display_on_q <= display_on_d;
      brightness_q <= brightness_d;
      frame_done_q <= frame_done_d;
      disp_data_q  <= disp_data_d;
      ram_q        <= ram_d;
    end
  end
  assign bus.dio_out = dio_out_q;
  assign bus.dio_oe  = dio_oe_q;
  assign disp_data   = disp_data_q;
  assign display_on  = display_on_q;
  assign brightness  = brightness_q;
  assign frame_done  = frame_done_q;
endmodule
